// File: rtl/imm_decode_pipe.sv
// Pipelined RISC-V immediate decoder with a valid/ready handshake, flush and a PC-relative target.
// Optional macro IMM_ILLEGAL_EN adds the oIllegal flag; without it oIllegal is tied to 0.
module imm_decode_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic            iValid,
    output logic            oReady,
    input  logic [31:0]     iInstruction,
    input  logic [XLEN-1:0] iPc,
    input  logic            iFlush,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oImm,
    output logic [2:0]      oFmt,
    output logic [XLEN-1:0] oTarget,
    output logic            oTargetValid,
    output logic            oIllegal
);
    localparam int LAST = STAGES - 1;

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            tgt_vld;
    } entry_t;

    // Build a full entry; every immediate is formed as a 32-bit value and sign-extended once.
    function automatic entry_t decode(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        entry_t      e;
        logic [31:0] imm32;
        logic        is_shift;
        e        = '0;
        imm32    = 32'd0;
        is_shift = (inst[14:12] == 3'b001) || (inst[14:12] == 3'b101);
        case (inst[6:0])
            OP_LOAD, OP_JALR: begin
                e.fmt = FMT_I;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OP_IMM: begin
                if (is_shift) begin
                    e.fmt = FMT_SHAMT;
                    imm32 = (XLEN == 64) ? {26'd0, inst[25:20]} : {27'd0, inst[24:20]};
                end else begin
                    e.fmt = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_IMM32: begin
                if (XLEN != 64) begin
                    e.fmt = FMT_NONE;
                end else if (is_shift) begin
                    e.fmt = FMT_SHAMT;
                    imm32 = {27'd0, inst[24:20]};
                end else begin
                    e.fmt = FMT_I;
                    imm32 = {{20{inst[31]}}, inst[31:20]};
                end
            end
            OP_STORE: begin
                e.fmt = FMT_S;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OP_BRANCH: begin
                e.fmt = FMT_B;
                imm32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                e.fmt = FMT_U;
                imm32 = {inst[31:12], 12'd0};
            end
            OP_JAL: begin
                e.fmt = FMT_J;
                imm32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                e.fmt = FMT_NONE;
            end
        endcase
        e.imm     = XLEN'($signed(imm32));
        e.tgt_vld = (e.fmt == FMT_B) || (e.fmt == FMT_J) || (inst[6:0] == OP_AUIPC);
        if (e.tgt_vld) begin
            e.target = pc + e.imm;
        end else begin
            e.target = '0;
        end
        return e;
    endfunction

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    entry_t            ent_q [STAGES];
    entry_t            ent_d [STAGES];
    entry_t            new_s;
    logic              load_last_s;
    logic              load_first_s;
    logic              in_fire_s;

    // Readiness ripples back from the output: a stage may load when empty or when it is draining.
    always_comb begin
        load_last_s = !valid_q[LAST] || iReady;
        if (STAGES == 2) begin
            load_first_s = !valid_q[0] || load_last_s;
        end else begin
            load_first_s = load_last_s;
        end
    end

    assign oReady    = load_first_s;
    assign in_fire_s = iValid && load_first_s && !iFlush;

    // Next-state for every stage; empty slots carry an all-zero payload.
    always_comb begin
        new_s   = decode(iInstruction, iPc);
        valid_d = valid_q;
        for (int k = 0; k < STAGES; k++) begin
            ent_d[k] = ent_q[k];
        end
        if (iFlush) begin
            valid_d = '0;
            for (int k = 0; k < STAGES; k++) begin
                ent_d[k] = '0;
            end
        end else begin
            if ((STAGES == 2) && load_last_s) begin
                valid_d[LAST] = valid_q[0];
                ent_d[LAST]   = ent_q[0];
            end else begin
                valid_d[LAST] = valid_q[LAST];
                ent_d[LAST]   = ent_q[LAST];
            end
            if (load_first_s) begin
                valid_d[0] = in_fire_s;
                ent_d[0]   = in_fire_s ? new_s : '0;
            end else begin
                valid_d[0] = valid_q[0];
                ent_d[0]   = ent_q[0];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ent_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < STAGES; k++) begin
                ent_q[k] <= ent_d[k];
            end
        end
    end

    assign oValid       = valid_q[LAST];
    assign oImm         = ent_q[LAST].imm;
    assign oFmt         = ent_q[LAST].fmt;
    assign oTarget      = ent_q[LAST].target;
    assign oTargetValid = ent_q[LAST].tgt_vld;

`ifdef IMM_ILLEGAL_EN
    logic [STAGES-1:0] illegal_q;
    logic [STAGES-1:0] illegal_d;
    logic              illegal_s;

    // Illegal flag travels alongside its entry using the same load conditions.
    always_comb begin
        illegal_s = (new_s.fmt == FMT_NONE) || (iInstruction[1:0] != 2'b11);
        illegal_d = illegal_q;
        if (iFlush) begin
            illegal_d = '0;
        end else begin
            if ((STAGES == 2) && load_last_s) begin
                illegal_d[LAST] = illegal_q[0];
            end else begin
                illegal_d[LAST] = illegal_q[LAST];
            end
            if (load_first_s) begin
                illegal_d[0] = in_fire_s && illegal_s;
            end else begin
                illegal_d[0] = illegal_q[0];
            end
        end
    end

    // Illegal flag register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            illegal_q <= '0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign oIllegal = illegal_q[LAST];
`else
    assign oIllegal = 1'b0;
`endif

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: a 32-bit single-stage instance and a 64-bit two-stage instance,
// checked against a behavioural decode model with a scoreboard queue.
module tb_imm_decode_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_iv, a_or, a_fl, a_ov, a_ir, a_tv, a_ill;
    logic [31:0] a_inst, a_pc, a_imm, a_tgt;
    logic [2:0]  a_fmt;
    logic        b_iv, b_or, b_fl, b_ov, b_ir, b_tv, b_ill;
    logic [31:0] b_inst;
    logic [63:0] b_pc, b_imm, b_tgt;
    logic [2:0]  b_fmt;

    imm_decode_pipe #(.XLEN(32), .STAGES(1)) u_a (
        .iClk(clk), .iRst(rst), .iValid(a_iv), .oReady(a_or), .iInstruction(a_inst), .iPc(a_pc),
        .iFlush(a_fl), .oValid(a_ov), .iReady(a_ir), .oImm(a_imm), .oFmt(a_fmt), .oTarget(a_tgt),
        .oTargetValid(a_tv), .oIllegal(a_ill));

    imm_decode_pipe #(.XLEN(64), .STAGES(2)) u_b (
        .iClk(clk), .iRst(rst), .iValid(b_iv), .oReady(b_or), .iInstruction(b_inst), .iPc(b_pc),
        .iFlush(b_fl), .oValid(b_ov), .iReady(b_ir), .oImm(b_imm), .oFmt(b_fmt), .oTarget(b_tgt),
        .oTargetValid(b_tv), .oIllegal(b_ill));

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        tv;
        logic        ill;
    } exp_t;

    exp_t q_exp [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Decode model: immediates assembled with signed arithmetic on the whole word.
    function automatic exp_t ref_model(input logic [31:0] inst, input logic [63:0] pc, input bit x64);
        exp_t       r;
        longint     w;
        logic [6:0] op;
        logic [2:0] f3;
        bit         sh;
        w     = longint'($signed(inst));
        op    = inst[6:0];
        f3    = inst[14:12];
        sh    = (f3 == 3'd1) || (f3 == 3'd5);
        r.imm = 64'd0;
        r.fmt = 3'd0;
        if (op == 7'h03 || op == 7'h67 || ((op == 7'h13 || (x64 && op == 7'h1B)) && !sh)) begin
            r.fmt = 3'd1;
            r.imm = w >>> 20;
        end else if (op == 7'h13 && sh) begin
            r.fmt = 3'd6;
            r.imm = x64 ? 64'(inst[25:20]) : 64'(inst[24:20]);
        end else if (x64 && op == 7'h1B && sh) begin
            r.fmt = 3'd6;
            r.imm = 64'(inst[24:20]);
        end else if (op == 7'h23) begin
            r.fmt = 3'd2;
            r.imm = (w >>> 25) * 32 + longint'(inst[11:7]);
        end else if (op == 7'h63) begin
            r.fmt = 3'd3;
            r.imm = (w >>> 31) * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                    + longint'(inst[11:8]) * 2;
        end else if (op == 7'h37 || op == 7'h17) begin
            r.fmt = 3'd4;
            r.imm = (w >>> 12) * 4096;
        end else if (op == 7'h6F) begin
            r.fmt = 3'd5;
            r.imm = (w >>> 31) * 1048576 + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                    + longint'(inst[30:21]) * 2;
        end
        r.tv  = (r.fmt == 3'd3) || (r.fmt == 3'd5) || (op == 7'h17);
        r.tgt = r.tv ? pc + r.imm : 64'd0;
        if (!x64) begin
            r.imm[63:32] = 32'd0;
            r.tgt[63:32] = 32'd0;
        end
`ifdef IMM_ILLEGAL_EN
        r.ill = (r.fmt == 3'd0) || (inst[1:0] != 2'b11);
`else
        r.ill = 1'b0;
`endif
        return r;
    endfunction

    task automatic set_in(input bit use_b, input logic v, input logic [31:0] inst,
                          input logic [63:0] pc, input logic rdy, input logic fl);
        a_iv   = use_b ? 1'b0 : v;
        a_inst = inst;
        a_pc   = pc[31:0];
        a_ir   = use_b ? 1'b1 : rdy;
        a_fl   = use_b ? 1'b0 : fl;
        b_iv   = use_b ? v : 1'b0;
        b_inst = inst;
        b_pc   = pc;
        b_ir   = use_b ? rdy : 1'b1;
        b_fl   = use_b ? fl : 1'b0;
    endtask

    task automatic obs(input bit use_b, output logic ov, output logic rdy, output exp_t o);
        if (use_b) begin
            ov = b_ov; rdy = b_or;
            o.imm = b_imm; o.fmt = b_fmt; o.tgt = b_tgt; o.tv = b_tv; o.ill = b_ill;
        end else begin
            ov = a_ov; rdy = a_or;
            o.imm = {32'd0, a_imm}; o.fmt = a_fmt; o.tgt = {32'd0, a_tgt}; o.tv = a_tv; o.ill = a_ill;
        end
    endtask

    task automatic check_entry(input string tag, input exp_t o, input exp_t e);
        chk({tag, "_imm"}, o.imm, e.imm);
        chk({tag, "_fmt"}, 64'(o.fmt), 64'(e.fmt));
        chk({tag, "_tgt"}, o.tgt, e.tgt);
        chk({tag, "_tv"}, 64'(o.tv), 64'(e.tv));
        chk({tag, "_ill"}, 64'(o.ill), 64'(e.ill));
    endtask

    // One instruction with iReady=1; checks latency and the fixed expected values.
    task automatic dir(input string tag, input bit use_b, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] x_imm, input logic [2:0] x_fmt, input logic [63:0] x_tgt,
                       input logic x_tv);
        exp_t e, o;
        logic ov, rdy;
        e = ref_model(inst, pc, use_b);
        @(negedge clk);
        set_in(use_b, 1'b1, inst, pc, 1'b1, 1'b0);
        #1 obs(use_b, ov, rdy, o);
        chk({tag, "_rdy"}, 64'(rdy), 64'd1);
        chk({tag, "_ov_accept"}, 64'(ov), 64'd0);
        @(negedge clk);
        set_in(use_b, 1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        #1 obs(use_b, ov, rdy, o);
        if (use_b) begin
            chk({tag, "_ov_lat1"}, 64'(ov), 64'd0);
            @(negedge clk);
            #1 obs(use_b, ov, rdy, o);
        end
        chk({tag, "_ov"}, 64'(ov), 64'd1);
        chk({tag, "_imm"}, o.imm, x_imm);
        chk({tag, "_fmt"}, 64'(o.fmt), 64'(x_fmt));
        chk({tag, "_tgt"}, o.tgt, x_tgt);
        chk({tag, "_tv"}, 64'(o.tv), 64'(x_tv));
        chk({tag, "_ill"}, 64'(o.ill), 64'(e.ill));
    endtask

    // Random traffic with back-pressure and flush against the scoreboard, then a drain.
    task automatic rand_run(input bit use_b, input int ncyc);
        exp_t        o;
        logic        ov, rdy, v, ir, fl;
        logic [31:0] inst;
        logic [63:0] pc;
        logic [6:0]  ops [11];
        int          depth, idx;
        bit          stall_prev, drain;
        ops = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h33};
        depth = use_b ? 2 : 1;
        q_exp.delete();
        stall_prev = 1'b0;
        for (int c = 0; c < ncyc + 12; c++) begin
            @(negedge clk);
            drain = (c >= ncyc);
            v     = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
            inst  = $urandom;
            idx   = $urandom_range(0, 11);
            if (idx < 11) inst[6:0] = ops[idx];
            if ($urandom_range(0, 9) == 0) inst[1:0] = 2'($urandom_range(0, 2));
            pc = {$urandom, $urandom};
            ir = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
            fl = drain ? 1'b0 : ($urandom_range(0, 24) == 0);
            set_in(use_b, v, inst, pc, ir, fl);
            #1 obs(use_b, ov, rdy, o);
            chk("rand_ready", 64'(rdy), 64'((q_exp.size() < depth) || ir));
            if (stall_prev) chk("rand_hold_valid", 64'(ov), 64'd1);
            if (ov) begin
                if (q_exp.size() == 0) chk("rand_spurious_valid", 64'(ov), 64'd0);
                else check_entry("rand", o, q_exp[0]);
            end
            if (ov && ir && q_exp.size() > 0) void'(q_exp.pop_front());
            stall_prev = ov && !ir && !fl;
            if (fl) q_exp.delete();
            else if (v && rdy) q_exp.push_back(ref_model(inst, pc, use_b));
        end
        #1 obs(use_b, ov, rdy, o);
        chk("rand_drain_empty", 64'(q_exp.size()), 64'd0);
        chk("rand_drain_ov", 64'(ov), 64'd0);
    endtask

    initial begin
        exp_t        o;
        logic        ov, rdy;
        logic [31:0] bp [3];
        bp = '{32'hFFF00093, 32'hFE112E23, 32'h001000EF};
        set_in(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        #2;
        chk("rst_a_ov", 64'(a_ov), 64'd0);
        chk("rst_a_imm", 64'(a_imm), 64'd0);
        chk("rst_b_ov", 64'(b_ov), 64'd0);
        chk("rst_b_tgt", b_tgt, 64'd0);
        chk("rst_b_fmt", 64'(b_fmt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        dir("addi", 1'b0, 32'hFFF00093, 64'h0, 64'hFFFFFFFF, 3'd1, 64'd0, 1'b0);
        dir("sw", 1'b0, 32'hFE112E23, 64'h0, 64'hFFFFFFFC, 3'd2, 64'd0, 1'b0);
        dir("srai", 1'b0, 32'h4030D093, 64'h0, 64'h3, 3'd6, 64'd0, 1'b0);
        dir("slli32", 1'b0, 32'h03F09093, 64'h0, 64'd31, 3'd6, 64'd0, 1'b0);
        dir("beq", 1'b0, 32'hFE000CE3, 64'h100, 64'hFFFFFFF8, 3'd3, 64'hF8, 1'b1);
        dir("jal", 1'b0, 32'h001000EF, 64'h1000, 64'h800, 3'd5, 64'h1800, 1'b1);
        dir("jal_wrap", 1'b0, 32'h001000EF, 64'hFFFFF800, 64'h800, 3'd5, 64'h0, 1'b1);
        dir("jalr", 1'b0, 32'h00008067, 64'h400, 64'h0, 3'd1, 64'd0, 1'b0);
        dir("op32_on_rv32", 1'b0, 32'h0030809B, 64'h0, 64'h0, 3'd0, 64'd0, 1'b0);
        dir("bad_op", 1'b0, 32'h0000007F, 64'h0, 64'h0, 3'd0, 64'd0, 1'b0);
        dir("lui64", 1'b1, 32'hDEADB0B7, 64'h0, 64'hFFFFFFFFDEADB000, 3'd4, 64'd0, 1'b0);
        dir("auipc64", 1'b1, 32'h00001097, 64'h2000, 64'h1000, 3'd4, 64'h3000, 1'b1);
        dir("slli64", 1'b1, 32'h03F09093, 64'h0, 64'd63, 3'd6, 64'd0, 1'b0);
        dir("slliw64", 1'b1, 32'h03F0909B, 64'h0, 64'd31, 3'd6, 64'd0, 1'b0);
        dir("addiw64", 1'b1, 32'hFFF0809B, 64'h0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'd0, 1'b0);
        dir("bad_op64", 1'b1, 32'h0000007F, 64'h0, 64'h0, 3'd0, 64'd0, 1'b0);

        // Two-stage back-pressure: two entries fit, the third waits.
        @(negedge clk); set_in(1'b1, 1'b1, bp[0], 64'h1000, 1'b0, 1'b0);
        #1 obs(1'b1, ov, rdy, o); chk("bp_rdy0", 64'(rdy), 64'd1);
        @(negedge clk); set_in(1'b1, 1'b1, bp[1], 64'h1000, 1'b0, 1'b0);
        #1 obs(1'b1, ov, rdy, o); chk("bp_rdy1", 64'(rdy), 64'd1); chk("bp_ov1", 64'(ov), 64'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); set_in(1'b1, 1'b1, bp[2], 64'h1000, 1'b0, 1'b0);
            #1 obs(1'b1, ov, rdy, o);
            chk("bp_rdy_full", 64'(rdy), 64'd0);
            chk("bp_ov_full", 64'(ov), 64'd1);
            check_entry("bp_hold", o, ref_model(bp[0], 64'h1000, 1'b1));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); set_in(1'b1, k == 0, bp[2], 64'h1000, 1'b1, 1'b0);
            #1 obs(1'b1, ov, rdy, o);
            if (k == 0) chk("bp_rdy_release", 64'(rdy), 64'd1);
            chk("bp_out_ov", 64'(ov), 64'd1);
            check_entry("bp_out", o, ref_model(bp[k], 64'h1000, 1'b1));
        end
        @(negedge clk); set_in(1'b1, 1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        #1 obs(1'b1, ov, rdy, o); chk("bp_empty", 64'(ov), 64'd0);

        // Flush with two entries in flight and a same-cycle input.
        @(negedge clk); set_in(1'b1, 1'b1, bp[0], 64'h1000, 1'b1, 1'b0);
        @(negedge clk); set_in(1'b1, 1'b1, bp[1], 64'h1000, 1'b1, 1'b0);
        @(negedge clk); set_in(1'b1, 1'b1, bp[2], 64'h1000, 1'b1, 1'b1);
        #1 obs(1'b1, ov, rdy, o);
        chk("fl_rdy", 64'(rdy), 64'd1);
        chk("fl_ov_before", 64'(ov), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); set_in(1'b1, 1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
            #1 obs(1'b1, ov, rdy, o); chk("fl_ov_after", 64'(ov), 64'd0);
        end

        // Asynchronous reset with both pipelines holding entries.
        @(negedge clk); set_in(1'b1, 1'b1, 32'hDEADB0B7, 64'h10, 1'b0, 1'b0);
        a_iv = 1'b1; a_ir = 1'b0; a_inst = 32'h001000EF; a_pc = 32'h1000;
        @(negedge clk); @(negedge clk);
        #1;
        chk("ar_b_ov_pre", 64'(b_ov), 64'd1);
        chk("ar_a_ov_pre", 64'(a_ov), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_b_ov", 64'(b_ov), 64'd0);
        chk("ar_b_imm", b_imm, 64'd0);
        chk("ar_b_fmt", 64'(b_fmt), 64'd0);
        chk("ar_a_ov", 64'(a_ov), 64'd0);
        chk("ar_a_tgt", 64'(a_tgt), 64'd0);
        chk("ar_a_tv", 64'(a_tv), 64'd0);
        chk("ar_a_ill", 64'(a_ill), 64'd0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        #1 chk("ar_b_ov_after", 64'(b_ov), 64'd0);

        rand_run(1'b0, 600);
        rand_run(1'b1, 600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
